// File: rtl/fu_wb_arbiter_pkg.sv
// Shared core types for the FU result path: payload struct, index type and counter helper.
// Optional build macro used by the arbiter: FU_WB_PERF_EN.
package fu_wb_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ID_W          = 6;
    localparam int unsigned PRD_W         = 7;
    localparam int unsigned NB_FU_DEFAULT = 4;

    typedef logic [$clog2(NB_FU_DEFAULT)-1:0] fu_idx_t;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [ID_W-1:0]  id;
        logic [PRD_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;

    // Saturating increment, holds at all ones.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/fu_wb_arbiter_fifo.sv
// Single-FU circular result FIFO; pointers carry one extra MSB to tell full from empty.
module fu_wb_fifo
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push_i,
    input  logic       pop_i,
    input  fu_output_t data_i,
    output logic       full_o,
    output logic       empty_o,
    output fu_output_t head_o
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    fu_output_t  mem_q [BUF_DEPTH];
    logic        push_s, pop_s;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_s  = push_i && !full_o;
    assign pop_s   = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage, cleared so no stale payload survives a reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Collects FU results into per-FU FIFOs and round-robins them onto one writeback port.
// Build macro FU_WB_PERF_EN adds saturating stall/conflict counters.
module fu_wb_arbiter
    import fu_wb_arbiter_pkg::*;
#(
    parameter int unsigned NB_FU     = NB_FU_DEFAULT,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NB_FU-1:0]         fu_valid_i,
    output logic [NB_FU-1:0]         fu_ready_o,
    input  fu_output_t               fuoutput_i [NB_FU],
    output logic                     wb_valid_o,
    input  logic                     wb_ready_i,
    output fu_output_t               wb_o,
    output logic [$clog2(NB_FU)-1:0] wb_src_o
`ifdef FU_WB_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt_o,
    output logic [31:0]              perf_conflict_cnt_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NB_FU);

    logic [NB_FU-1:0] full_s, empty_s, pop_s;
    fu_output_t       head_s [NB_FU];
    logic [IDX_W-1:0] grant_s, cand_s;
    logic             found_s, hit_s, handshake_s;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    for (genvar g = 0; g < int'(NB_FU); g++) begin : g_fifo
        fu_wb_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .push_i  (fu_valid_i[g]),
            .pop_i   (pop_s[g]),
            .data_i  (fuoutput_i[g]),
            .full_o  (full_s[g]),
            .empty_o (empty_s[g]),
            .head_o  (head_s[g])
        );
    end

    assign fu_ready_o  = ~full_s;
    assign wb_valid_o  = |(~empty_s);
    assign handshake_s = wb_valid_o && wb_ready_i;
    assign wb_o        = wb_valid_o ? head_s[grant_s] : '0;
    assign wb_src_o    = wb_valid_o ? grant_s : '0;

    // Grant: the locked index during a stall, otherwise first non-empty after last_grant.
    always_comb begin
        grant_s = last_grant_q;
        found_s = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        if (lock_q) begin
            grant_s = lock_idx_q;
        end else begin
            for (int unsigned k = 1; k <= NB_FU; k++) begin
                cand_s  = IDX_W'((32'(last_grant_q) + k) % NB_FU);
                hit_s   = !found_s && !empty_s[cand_s];
                grant_s = hit_s ? cand_s : grant_s;
                found_s = found_s | hit_s;
            end
        end
    end

    // One-hot pop of the granted FIFO on handshake.
    always_comb begin
        pop_s = '0;
        if (handshake_s) begin
            pop_s[grant_s] = 1'b1;
        end else begin
            pop_s = '0;
        end
    end

    // Lock and round-robin pointer next-state.
    always_comb begin
        lock_d       = lock_q;
        lock_idx_d   = lock_idx_q;
        last_grant_d = last_grant_q;
        if (handshake_s) begin
            lock_d       = 1'b0;
            last_grant_d = grant_s;
        end else if (wb_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_s;
        end else begin
            lock_d = 1'b0;
        end
    end

    // Arbiter state registers; FU0 gets first priority after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            last_grant_q <= IDX_W'(NB_FU - 1);
        end else begin
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef FU_WB_PERF_EN
    logic [IDX_W:0] nonempty_cnt_s;
    logic [31:0]    stall_cnt_q, conflict_cnt_q;

    // Number of non-empty FIFOs this cycle.
    always_comb begin
        nonempty_cnt_s = '0;
        for (int i = 0; i < int'(NB_FU); i++) begin
            nonempty_cnt_s = nonempty_cnt_s + {{IDX_W{1'b0}}, ~empty_s[i]};
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q    <= 32'd0;
            conflict_cnt_q <= 32'd0;
        end else begin
            if (wb_valid_o && !wb_ready_i) begin
                stall_cnt_q <= sat_inc32(stall_cnt_q);
            end
            if (nonempty_cnt_s >= (IDX_W+1)'(2)) begin
                conflict_cnt_q <= sat_inc32(conflict_cnt_q);
            end
        end
    end

    assign perf_stall_cnt_o    = stall_cnt_q;
    assign perf_conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Consumer end of the functional-unit result interface (fu_output_t).
- Collects results from NB_FU functional units (ALU, MUL, LSU, ...) into per-FU FIFOs.
- Round-robin arbitrates them onto one writeback port that feeds the register file, wakeup and ROB completion.
- Decouples FU completion timing from writeback-port availability.

Parameters:
- NB_FU, 4, number of FU result sources (≥2).
- BUF_DEPTH, 2, entries per FU FIFO (power of two, ≥2).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- fu_valid_i  in  NB_FU  result valid per FU.
- fu_ready_o  out  NB_FU  FIFO can accept per FU.
- fuoutput_i  in  NB_FU x fu_output_t  results {pc, id, prd, rdval}.
- wb_valid_o  out  1  writeback valid.
- wb_ready_i  in  1  writeback consumer accepts.
- wb_o  out  fu_output_t  selected result.
- wb_src_o  out  $clog2(NB_FU)  index of granted FU.

Behaviour:
- Reset (async, rstn=0), all FIFOs empty:
  - fu_ready_o = all ones.
  - wb_valid_o = 0.
  - wb_o = '0.
  - wb_src_o = 0.
  - RR pointer last_grant = NB_FU-1, so FU0 has first priority.
- Push handshake:
  - FU i pushes when fu_valid_i[i] && fu_ready_o[i].
  - fu_ready_o[i] = !full[i], driven from registers only. There is no combinational path from wb_ready_i or fu_valid_i.
  - When full, push is refused even if a pop occurs in the same cycle.
- FIFO structure:
  - Per-FU circular buffer with rd/wr pointers of $clog2(BUF_DEPTH)+1 bits. The extra MSB distinguishes full from empty.
  - Full = MSBs differ and low bits equal. Empty = pointers equal.
  - Pointers wrap modulo 2*BUF_DEPTH.
- Latency: a result pushed at edge t is visible on wb_o in cycle t+1 at the earliest. The head is read combinationally from FIFO storage.
- Arbitration:
  - Candidates are FIFOs with !empty.
  - The grant goes to the first non-empty index searching from last_grant+1 upward, modulo NB_FU.
  - wb_valid_o = any non-empty. wb_o = head of granted FIFO. wb_src_o = grant index.
- Pop and pointer update:
  - On wb_valid_o && wb_ready_i, pop the granted FIFO and set last_grant = grant.
  - last_grant does not change without a handshake.
- Stall stability: while wb_valid_o && !wb_ready_i, the grant is locked (registered lock flag plus locked index). wb_o and wb_src_o hold stable even if a higher-priority FIFO becomes non-empty. The lock releases on handshake.
- Simultaneous push and pop on the same FIFO: both take effect. Occupancy is unchanged. Ordering within one FU is strict FIFO.
- Empty FIFO with a push in the same cycle: no bypass. The entry is visible the next cycle.
- wb_ready_i asserted while wb_valid_o=0: no effect.
- Reset mid-operation: all buffered results are discarded, the lock clears, and the outputs return to their reset values immediately.
- Data width: fu_output_t is passed unmodified; there is no arithmetic on the payload.

Optional Feature:
- Macro: FU_WB_PERF_EN.
- Defined: adds output perf_stall_cnt_o (32 bits) and output perf_conflict_cnt_o (32 bits).
  - perf_stall_cnt_o counts cycles with wb_valid_o && !wb_ready_i.
  - perf_conflict_cnt_o counts cycles with ≥2 non-empty FIFOs.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared core package already holds fu_output_t and XLEN. Add there:
  - constant NB_FU_DEFAULT;
  - typedef fu_idx_t = logic [$clog2(NB_FU)-1:0].
- One sub-module, fu_wb_fifo: single-FU circular FIFO with push/pop/full/empty/head, instantiated NB_FU times.
- Round-robin arbiter logic stays inline.

Test Plan:
- Single result, FU2 pushes {id=5, prd=12, rdval=0xDEAD} at edge t with wb_ready_i=1 -> wb_valid_o=1 in cycle t+1, wb_src_o=2, payload exact; empty at t+2.
- Round-robin, FU0 and FU1 and FU3 push in the same cycle, wb_ready_i=1 -> grants 0, 1, 3 on consecutive cycles; a next simultaneous FU0+FU3 push yields 0 then 3.
- Backpressure, wb_ready_i=0, FU1 pushes 3 times with BUF_DEPTH=2 -> fu_ready_o[1]=0 after 2 pushes, third held by FU; raise wb_ready_i -> pops in order, ready returns next cycle.
- Stall stability: grant FU3 stalled 4 cycles, FU0 pushes meanwhile -> wb_o/wb_src_o=3 unchanged throughout; FU0 served right after the handshake.
- Reset mid-op: 2 entries in each FIFO, rstn pulsed low asynchronously mid-cycle -> wb_valid_o=0 immediately, fu_ready_o all ones, no stale result after release.
- FU_WB_PERF_EN: 3 stall cycles and 2 conflict cycles -> perf_stall_cnt_o=3, perf_conflict_cnt_o=2.
